// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and status signal bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   // port 0 (processor core)
   logic          p0_req;
   logic          p0_we;
   logic          p0_lock;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata;
   logic          p0_ack;
   logic [DW-1:0] p0_rdata;

   // port 1 (loader / debug master)
   logic          p1_req;
   logic          p1_we;
   logic          p1_lock;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata;
   logic          p1_ack;
   logic [DW-1:0] p1_rdata;

   // single-port synchronous RAM
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // status
   logic          busy;
   logic          owner;

   // arbiter side
   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      input  mem_rdata,
      output p0_ack, p0_rdata, p1_ack, p1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, owner
   );

   // requesters and memory side
   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      output mem_rdata,
      input  p0_ack, p0_rdata, p1_ack, p1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter with bounded lock in front of a 1-cycle-latency RAM
module mem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_LOCK = 8
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int LCW = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          state, state_d;
   logic            owner_q, owner_d;
   logic            lock_flag_q, lock_flag_d;   // winner's lock input at its last grant
   logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
   logic            we_q, we_d;                 // latched direction, survives past ISSUE
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            ack0_q, ack0_d;
   logic            ack1_q, ack1_d;
   logic [DW-1:0]   rdata0_q, rdata0_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;
   logic            busy_q, busy_d;

   logic            elig0, elig1;
   logic            lock_win;
   logic            winner;

   // Eligibility (a req seen during its own ack cycle is stale) and winner pick
   always_comb begin
      elig0    = bus.p0_req && !ack0_q;
      elig1    = bus.p1_req && !ack1_q;
      lock_win = lock_flag_q && (lock_cnt_q < LCW'(MAX_LOCK)) &&
                 (owner_q ? elig1 : elig0);
      if (lock_win) begin
         winner = owner_q;
      end else if (elig0 && elig1) begin
         winner = !owner_q;
      end else begin
         winner = elig1;
      end
   end

   // Next-state and registered-output values
   always_comb begin
      state_d     = state;
      owner_d     = owner_q;
      lock_flag_d = lock_flag_q;
      lock_cnt_d  = lock_cnt_q;
      we_d        = we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;

      case (state)
         IDLE: begin
            if (elig0 || elig1) begin
               owner_d     = winner;
               lock_flag_d = winner ? bus.p1_lock : bus.p0_lock;
               lock_cnt_d  = lock_win ? (lock_cnt_q + LCW'(1)) : '0;
               we_d        = winner ? bus.p1_we    : bus.p0_we;
               addr_d      = winner ? bus.p1_addr  : bus.p0_addr;
               wdata_d     = winner ? bus.p1_wdata : bus.p0_wdata;
               mem_en_d    = 1'b1;
               mem_we_d    = winner ? bus.p1_we    : bus.p0_we;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            state_d = RESP;
         end
         RESP: begin
            if (!we_q) begin
               if (owner_q) begin
                  rdata1_d = bus.mem_rdata;
               end else begin
                  rdata0_d = bus.mem_rdata;
               end
            end
            if (owner_q) begin
               ack1_d = 1'b1;
            end else begin
               ack0_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; owner resets to 1 so port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner_q     <= 1'b1;
         lock_flag_q <= 1'b0;
         lock_cnt_q  <= '0;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_d;
         owner_q     <= owner_d;
         lock_flag_q <= lock_flag_d;
         lock_cnt_q  <= lock_cnt_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.p0_ack    = ack0_q;
   assign bus.p1_ack    = ack1_q;
   assign bus.p0_rdata  = rdata0_q;
   assign bus.p1_rdata  = rdata1_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;

endmodule
